// File: rtl/load_store_unit.sv
// Memory stage: issues one byte/half/word access over a req/gnt/rvalid port and returns
// aligned, extended load data. Optional misaligned-access trap via `MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int WORD       = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  is_valid_i,
  input  logic                  flush_i,
  input  logic [1:0]            mem_op_i,
  input  logic [1:0]            size_i,
  input  logic                  sign_ext_i,
  input  logic [WORD-1:0]       addr_i,
  input  logic [WORD-1:0]       store_data_i,
  input  logic [REG_ADDR_W-1:0] dest_reg_i,
  output logic                  stall_o,
  output logic                  load_valid_o,
  output logic [WORD-1:0]       load_data_o,
  output logic [REG_ADDR_W-1:0] load_dest_o,
  output logic                  align_fault_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [WORD-1:0]       mem_addr_o,
  output logic [WORD-1:0]       mem_wdata_o,
  output logic [WORD/8-1:0]     mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [WORD-1:0]       mem_rdata_i
);

  // state     | meaning
  // S_IDLE    | no access outstanding, ready to accept
  // S_REQ     | mem_req_o asserted, waiting for gnt
  // S_WAIT    | load granted, waiting for rvalid
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam int LANES = WORD / 8;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;

  logic [1:0]            r_state;
  logic [WORD-1:0]       r_addr;
  logic [WORD-1:0]       r_wdata;
  logic [LANES-1:0]      r_be;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_sign;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_killed;
  logic                  r_load_valid;
  logic [WORD-1:0]       r_load_data;
  logic [REG_ADDR_W-1:0] r_load_dest;

  logic                  w_op_valid;
  logic                  w_accept;
  logic                  w_issue;
  logic                  w_complete;
  logic                  w_in_req;
  logic [WORD-1:0]       w_addr_adj;
  logic [LANES-1:0]      w_be;
  logic [WORD-1:0]       w_wdata;
  logic [WORD-1:0]       w_shifted;
  logic [WORD-1:0]       w_ext;

  assign w_op_valid = (mem_op_i == OP_LOAD) || (mem_op_i == OP_STORE);
  assign w_accept   = (r_state == S_IDLE) && is_valid_i && w_op_valid && !flush_i;

`ifdef MISALIGN_TRAP_EN
  logic w_misaligned;
  logic r_align_fault;

  assign w_misaligned = (size_i == SZ_HALF) ? addr_i[0]
                      : (size_i[1] && (addr_i[1:0] != 2'b00));
  assign w_issue       = w_accept && !w_misaligned;
  assign w_addr_adj    = addr_i;
  assign align_fault_o = r_align_fault;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_align_fault <= 1'b0;
    else            r_align_fault <= w_accept && w_misaligned;
  end
`else
  assign w_issue       = w_accept;
  assign align_fault_o = 1'b0;

  // Misaligned low address bits are silently dropped so the access stays in one word.
  always_comb begin
    w_addr_adj = addr_i;
    case (size_i)
      SZ_BYTE: w_addr_adj = addr_i;
      SZ_HALF: w_addr_adj = {addr_i[WORD-1:1], 1'b0};
      default: w_addr_adj = {addr_i[WORD-1:2], 2'b00};
    endcase
  end
`endif

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data_i;
    case (size_i)
      SZ_BYTE: begin
        w_be    = 4'b0001 << w_addr_adj[1:0];
        w_wdata = {(WORD/8){store_data_i[7:0]}};
      end
      SZ_HALF: begin
        w_be    = w_addr_adj[1] ? 4'b1100 : 4'b0011;
        w_wdata = {(WORD/16){store_data_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data_i;
      end
    endcase
  end

  assign w_shifted = mem_rdata_i >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = w_shifted;
    case (r_size)
      SZ_BYTE: w_ext = {{(WORD-8){r_sign & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: w_ext = {{(WORD-16){r_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  assign w_complete = ((r_state == S_REQ) && mem_gnt_i && r_we) ||
                      ((r_state == S_WAIT) && mem_rvalid_i);
  assign stall_o    = w_accept || ((r_state != S_IDLE) && !w_complete);

  assign w_in_req    = (r_state == S_REQ);
  assign mem_req_o   = w_in_req;
  assign mem_we_o    = w_in_req && r_we;
  assign mem_addr_o  = w_in_req ? {r_addr[WORD-1:2], 2'b00} : '0;
  assign mem_wdata_o = w_in_req ? r_wdata : '0;
  assign mem_be_o    = w_in_req ? r_be : '0;

  assign load_valid_o = r_load_valid;
  assign load_data_o  = r_load_data;
  assign load_dest_o  = r_load_dest;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_we         <= 1'b0;
      r_size       <= '0;
      r_sign       <= 1'b0;
      r_dest       <= '0;
      r_killed     <= 1'b0;
      r_load_valid <= 1'b0;
      r_load_data  <= '0;
      r_load_dest  <= '0;
    end else begin
      r_load_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state  <= S_REQ;
            r_addr   <= w_addr_adj;
            r_wdata  <= w_wdata;
            r_be     <= w_be;
            r_we     <= (mem_op_i == OP_STORE);
            r_size   <= size_i;
            r_sign   <= sign_ext_i;
            r_dest   <= dest_reg_i;
            r_killed <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            // A flush in the grant cycle cannot recall the request; a load must still drain.
            if (r_we) begin
              r_state <= S_IDLE;
            end else begin
              r_state  <= S_WAIT;
              r_killed <= flush_i;
            end
          end else if (flush_i) begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            r_state <= S_IDLE;
            if (!(r_killed || flush_i)) begin
              r_load_valid <= 1'b1;
              r_load_data  <= w_ext;
              r_load_dest  <= r_dest;
            end
          end else if (flush_i) begin
            r_killed <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; memory responses are driven by hand.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        is_valid_i, flush_i, sign_ext_i;
  logic [1:0]  mem_op_i, size_i;
  logic [31:0] addr_i, store_data_i;
  logic [3:0]  dest_reg_i;
  logic        stall_o, load_valid_o, align_fault_o;
  logic [31:0] load_data_o;
  logic [3:0]  load_dest_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_pass = 0;
  int n_total = 0;

  load_store_unit #(.WORD(32), .REG_ADDR_W(4)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .is_valid_i(is_valid_i), .flush_i(flush_i),
    .mem_op_i(mem_op_i), .size_i(size_i), .sign_ext_i(sign_ext_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .dest_reg_i(dest_reg_i), .stall_o(stall_o),
    .load_valid_o(load_valid_o), .load_data_o(load_data_o), .load_dest_o(load_dest_o),
    .align_fault_o(align_fault_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    is_valid_i = 0; flush_i = 0; sign_ext_i = 0; mem_op_i = 0; size_i = 0;
    addr_i = 0; store_data_i = 0; dest_reg_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic present(input logic [1:0] op, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] dst);
    is_valid_i = 1; mem_op_i = op; size_i = sz; sign_ext_i = sgn;
    addr_i = a; store_data_i = d; dest_reg_i = dst;
  endtask

  // Accept, grant immediately, rvalid next cycle; returns in the cycle load_valid_o should pulse.
  task automatic run_load(input logic [1:0] sz, input logic sgn, input logic [31:0] a,
                          input logic [3:0] dst, input logic [31:0] rdata);
    present(2'd1, sz, sgn, a, 32'h0, dst);
    step();
    clear_inputs();
    mem_gnt_i = 1;
    step();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = rdata;
    step();
    mem_rvalid_i = 0; mem_rdata_i = 0;
    #1;
  endtask

  task automatic test_reset();
    reset_n_i = 0;
    clear_inputs();
    #3;
    n_total++; if (stall_o !== 0) $display("FAIL rst_stall got=%0b exp=0", stall_o); else n_pass++;
    n_total++; if ({load_valid_o, load_data_o, load_dest_o, align_fault_o} !== 38'h0)
      $display("FAIL rst_load_outs got=%0h exp=0", {load_valid_o, load_data_o, load_dest_o, align_fault_o}); else n_pass++;
    n_total++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== 70'h0)
      $display("FAIL rst_mem_bus got=%0h exp=0", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o}); else n_pass++;
    #9 reset_n_i = 1;
    step();
  endtask

  task automatic test_load_word();
    present(2'd1, 2'd2, 1'b0, 32'h100, 32'h0, 4'd5);
    #1;
    n_total++; if (stall_o !== 1) $display("FAIL lw_accept_stall got=%0b exp=1", stall_o); else n_pass++;
    n_total++; if (mem_req_o !== 0) $display("FAIL lw_accept_req got=%0b exp=0", mem_req_o); else n_pass++;
    step();
    clear_inputs();
    mem_gnt_i = 1;
    #1;
    n_total++; if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b10_1111)
      $display("FAIL lw_req_ctrl got=%b exp=101111", {mem_req_o, mem_we_o, mem_be_o}); else n_pass++;
    n_total++; if (mem_addr_o !== 32'h100) $display("FAIL lw_req_addr got=%h exp=00000100", mem_addr_o); else n_pass++;
    n_total++; if (stall_o !== 1) $display("FAIL lw_req_stall got=%0b exp=1", stall_o); else n_pass++;
    step();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    #1;
    n_total++; if (stall_o !== 0) $display("FAIL lw_rvalid_stall got=%0b exp=0", stall_o); else n_pass++;
    n_total++; if (mem_req_o !== 0) $display("FAIL lw_wait_req got=%0b exp=0", mem_req_o); else n_pass++;
    step();
    mem_rvalid_i = 0;
    #1;
    n_total++; if (load_valid_o !== 1) $display("FAIL lw_valid got=%0b exp=1", load_valid_o); else n_pass++;
    n_total++; if (load_data_o !== 32'hDEADBEEF) $display("FAIL lw_data got=%h exp=deadbeef", load_data_o); else n_pass++;
    n_total++; if (load_dest_o !== 4'd5) $display("FAIL lw_dest got=%0d exp=5", load_dest_o); else n_pass++;
    step();
    n_total++; if (load_valid_o !== 0) $display("FAIL lw_pulse_end got=%0b exp=0", load_valid_o); else n_pass++;
    n_total++; if (load_data_o !== 32'hDEADBEEF) $display("FAIL lw_data_hold got=%h exp=deadbeef", load_data_o); else n_pass++;
  endtask

  task automatic test_load_extend();
    run_load(2'd0, 1'b1, 32'h103, 4'd7, 32'h80112233);
    n_total++; if ({load_valid_o, load_dest_o} !== 5'b1_0111)
      $display("FAIL lb_s_valid_dest got=%b exp=10111", {load_valid_o, load_dest_o}); else n_pass++;
    n_total++; if (load_data_o !== 32'hFFFFFF80) $display("FAIL lb_s_data got=%h exp=ffffff80", load_data_o); else n_pass++;
    run_load(2'd1, 1'b0, 32'h102, 4'd2, 32'h80112233);
    n_total++; if (load_data_o !== 32'h00008011) $display("FAIL lh_u_data got=%h exp=00008011", load_data_o); else n_pass++;
    run_load(2'd1, 1'b1, 32'h102, 4'd2, 32'h80112233);
    n_total++; if (load_data_o !== 32'hFFFF8011) $display("FAIL lh_s_data got=%h exp=ffff8011", load_data_o); else n_pass++;
    run_load(2'd0, 1'b0, 32'h103, 4'd3, 32'h80112233);
    n_total++; if (load_data_o !== 32'h00000080) $display("FAIL lb_u_data got=%h exp=00000080", load_data_o); else n_pass++;
    run_load(2'd0, 1'b1, 32'h101, 4'd4, 32'h80112233);
    n_total++; if (load_data_o !== 32'h00000022) $display("FAIL lb_s_lane1 got=%h exp=00000022", load_data_o); else n_pass++;
    step();
  endtask

  task automatic test_store();
    present(2'd2, 2'd1, 1'b0, 32'h206, 32'h0000ABCD, 4'd0);
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if ({mem_req_o, mem_we_o, mem_be_o, stall_o} !== 7'b11_1100_1)
        $display("FAIL sh_hold_ctrl%0d got=%b exp=1111001", i, {mem_req_o, mem_we_o, mem_be_o, stall_o}); else n_pass++;
      n_total++; if ({mem_addr_o, mem_wdata_o} !== {32'h204, 32'hABCDABCD})
        $display("FAIL sh_hold_bus%0d got=%h exp=00000204abcdabcd", i, {mem_addr_o, mem_wdata_o}); else n_pass++;
      step();
    end
    mem_gnt_i = 1;
    #1;
    n_total++; if ({mem_req_o, stall_o} !== 2'b10) $display("FAIL sh_gnt got=%b exp=10", {mem_req_o, stall_o}); else n_pass++;
    step();
    mem_gnt_i = 0;
    #1;
    n_total++; if ({mem_req_o, mem_be_o, stall_o} !== 6'b0) $display("FAIL sh_done got=%b exp=000000", {mem_req_o, mem_be_o, stall_o}); else n_pass++;
    present(2'd2, 2'd0, 1'b0, 32'h301, 32'h12345678, 4'd0);
    step();
    clear_inputs();
    mem_gnt_i = 1;
    #1;
    n_total++; if ({mem_be_o, mem_wdata_o, mem_addr_o} !== {4'b0010, 32'h78787878, 32'h300})
      $display("FAIL sb_lane got=%h exp=27878787800000300", {mem_be_o, mem_wdata_o, mem_addr_o}); else n_pass++;
    step();
    mem_gnt_i = 0;
  endtask

  task automatic test_flush();
    // Flush while waiting for rvalid: response is consumed silently.
    present(2'd1, 2'd2, 1'b0, 32'h100, 32'h0, 4'd6);
    step();
    clear_inputs();
    mem_gnt_i = 1;
    step();
    mem_gnt_i = 0; flush_i = 1;
    #1;
    n_total++; if (stall_o !== 1) $display("FAIL fw_stall got=%0b exp=1", stall_o); else n_pass++;
    step();
    flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11111111;
    #1;
    n_total++; if (stall_o !== 0) $display("FAIL fw_rvalid_stall got=%0b exp=0", stall_o); else n_pass++;
    step();
    mem_rvalid_i = 0;
    #1;
    n_total++; if ({load_valid_o, load_data_o} !== {1'b0, 32'h00000022})
      $display("FAIL fw_suppress got=%h exp=000000022", {load_valid_o, load_data_o}); else n_pass++;
    // Flush in the grant cycle of a load.
    present(2'd1, 2'd2, 1'b0, 32'h100, 32'h0, 4'd6);
    step();
    clear_inputs();
    mem_gnt_i = 1; flush_i = 1;
    step();
    mem_gnt_i = 0; flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h22222222;
    #1;
    n_total++; if ({mem_req_o, stall_o} !== 2'b00) $display("FAIL fg_rvalid got=%b exp=00", {mem_req_o, stall_o}); else n_pass++;
    step();
    mem_rvalid_i = 0;
    #1;
    n_total++; if (load_valid_o !== 0) $display("FAIL fg_suppress got=%0b exp=0", load_valid_o); else n_pass++;
    // Flush in REQ before grant.
    present(2'd1, 2'd2, 1'b0, 32'h100, 32'h0, 4'd6);
    step();
    clear_inputs();
    flush_i = 1;
    #1;
    n_total++; if (mem_req_o !== 1) $display("FAIL fr_req_held got=%0b exp=1", mem_req_o); else n_pass++;
    step();
    flush_i = 0;
    #1;
    n_total++; if ({mem_req_o, stall_o} !== 2'b00) $display("FAIL fr_dropped got=%b exp=00", {mem_req_o, stall_o}); else n_pass++;
    // Flush together with accept, then spurious rvalid while idle.
    present(2'd2, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, 4'd0);
    flush_i = 1;
    #1;
    n_total++; if (stall_o !== 0) $display("FAIL fa_stall got=%0b exp=0", stall_o); else n_pass++;
    step();
    clear_inputs();
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    #1;
    n_total++; if (mem_req_o !== 0) $display("FAIL fa_no_req got=%0b exp=0", mem_req_o); else n_pass++;
    step();
    mem_rvalid_i = 0;
    #1;
    n_total++; if (load_valid_o !== 0) $display("FAIL spur_rvalid got=%0b exp=0", load_valid_o); else n_pass++;
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    present(2'd1, 2'd2, 1'b0, 32'h101, 32'h0, 4'd1);
    #1;
    n_total++; if (stall_o !== 1) $display("FAIL ma_trap_stall got=%0b exp=1", stall_o); else n_pass++;
    step();
    clear_inputs();
    #1;
    n_total++; if ({mem_req_o, align_fault_o, stall_o} !== 3'b010)
      $display("FAIL ma_trap_fault got=%b exp=010", {mem_req_o, align_fault_o, stall_o}); else n_pass++;
    step();
    n_total++; if ({mem_req_o, align_fault_o, load_valid_o} !== 3'b000)
      $display("FAIL ma_trap_end got=%b exp=000", {mem_req_o, align_fault_o, load_valid_o}); else n_pass++;
`else
    present(2'd1, 2'd2, 1'b0, 32'h101, 32'h0, 4'd1);
    step();
    clear_inputs();
    #1;
    n_total++; if ({mem_req_o, mem_be_o, align_fault_o} !== 6'b1_1111_0)
      $display("FAIL ma_ctrl got=%b exp=111110", {mem_req_o, mem_be_o, align_fault_o}); else n_pass++;
    n_total++; if (mem_addr_o !== 32'h100) $display("FAIL ma_addr got=%h exp=00000100", mem_addr_o); else n_pass++;
    mem_gnt_i = 1;
    step();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0A0B0C0D;
    step();
    mem_rvalid_i = 0;
    #1;
    n_total++; if (load_data_o !== 32'h0A0B0C0D) $display("FAIL ma_word_data got=%h exp=0a0b0c0d", load_data_o); else n_pass++;
    run_load(2'd1, 1'b0, 32'h203, 4'd1, 32'h80112233);
    n_total++; if (load_data_o !== 32'h00008011) $display("FAIL ma_half_data got=%h exp=00008011", load_data_o); else n_pass++;
`endif
    step();
  endtask

  task automatic test_reset_mid();
    present(2'd1, 2'd2, 1'b0, 32'h100, 32'h0, 4'd8);
    step();
    clear_inputs();
    mem_gnt_i = 1;
    step();
    mem_gnt_i = 0;
    #1 reset_n_i = 0;
    #1;
    n_total++; if ({stall_o, mem_req_o, load_valid_o, load_data_o, load_dest_o} !== 39'h0)
      $display("FAIL rm_outs got=%h exp=0", {stall_o, mem_req_o, load_valid_o, load_data_o, load_dest_o}); else n_pass++;
    #1 reset_n_i = 1;
    step();
    run_load(2'd2, 1'b0, 32'h10C, 4'd9, 32'h13572468);
    n_total++; if ({load_valid_o, load_dest_o, load_data_o} !== {1'b1, 4'd9, 32'h13572468})
      $display("FAIL rm_after got=%h exp=1913572468", {load_valid_o, load_dest_o, load_data_o}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    present(2'd2, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, 4'd0);
    #1;
    n_total++; if (stall_o !== 1) $display("FAIL b2b_accept got=%0b exp=1", stall_o); else n_pass++;
    step();
    clear_inputs();
    mem_gnt_i = 1;
    #1;
    n_total++; if ({mem_req_o, mem_we_o, mem_be_o, mem_wdata_o} !== {2'b11, 4'b1111, 32'hCAFEF00D})
      $display("FAIL b2b_store got=%h exp=3fcafef00d", {mem_req_o, mem_we_o, mem_be_o, mem_wdata_o}); else n_pass++;
    step();
    mem_gnt_i = 0;
    #1;
    n_total++; if ({mem_req_o, stall_o} !== 2'b00) $display("FAIL b2b_done got=%b exp=00", {mem_req_o, stall_o}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_flush();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
